// File: rtl/adc_bus_responder.sv
// adc_bus_responder: AD7822-style parallel ADC emulation (track/hold, conversion delay, EOC pulse, RD-gated bus).
// Define ADC_BUS_RESPONDER_SYNC_EN to pass CONVST/CS/RD through 2-flop synchronizers (+2 cycles on strobe latencies).
module adc_bus_responder #(
  parameter int DATA_W      = 8,
  parameter int CONV_CYCLES = 66,
  parameter int EOC_CYCLES  = 10,
  parameter int RD_ACCESS   = 2
) (
  input  logic              Clk,
  input  logic              adcRst,
  input  logic              CONVST,
  input  logic              CS,
  input  logic              RD,
  input  logic [DATA_W-1:0] sampleIn,
  output logic [DATA_W-1:0] D,
  output logic              dOe,
  output logic              EOC,
  output logic              busy,
  output logic              overrun
);

  localparam int MAX_CYCLES = (CONV_CYCLES > EOC_CYCLES) ? CONV_CYCLES : EOC_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int ACC_W      = (RD_ACCESS > 1) ? $clog2(RD_ACCESS) : 1;
  localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] EOC_LOAD  = CNT_W'(EOC_CYCLES - 1);
  localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(RD_ACCESS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, EOC_PULSE, READY} stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [DATA_W-1:0] hold, holdNext;
  logic [DATA_W-1:0] result, resultNext;
  logic              eocNext, busyNext, overrunNext;
  logic              convstS, csS, rdS;
  logic              convstQ;
  logic              convFall, rdq, dOeRise;
  logic [ACC_W-1:0]  acc;

`ifdef ADC_BUS_RESPONDER_SYNC_EN
  logic [1:0] convstSync, csSync, rdSync;

  always_ff @(posedge Clk or negedge adcRst) begin
    if (!adcRst) begin
      convstSync <= 2'b11;
      csSync     <= 2'b11;
      rdSync     <= 2'b11;
    end else begin
      convstSync <= {convstSync[0], CONVST};
      csSync     <= {csSync[0], CS};
      rdSync     <= {rdSync[0], RD};
    end
  end

  assign convstS = convstSync[1];
  assign csS     = csSync[1];
  assign rdS     = rdSync[1];
`else
  assign convstS = CONVST;
  assign csS     = CS;
  assign rdS     = RD;
`endif

  assign convFall = convstQ & ~convstS;
  assign rdq      = ~csS & ~rdS;
  assign dOeRise  = rdq & ~dOe & (acc == ACC_LAST);

  always_ff @(posedge Clk or negedge adcRst) begin
    if (!adcRst) begin
      state   <= IDLE;
      cnt     <= '0;
      hold    <= '0;
      result  <= '0;
      EOC     <= 1'b1;
      busy    <= 1'b0;
      overrun <= 1'b0;
      convstQ <= 1'b1;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      hold    <= holdNext;
      result  <= resultNext;
      EOC     <= eocNext;
      busy    <= busyNext;
      overrun <= overrunNext;
      convstQ <= convstS;
    end
  end

  // A CONVST fall while a conversion or its EOC pulse is pending never restarts; it only flags overrun.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    holdNext    = hold;
    resultNext  = result;
    eocNext     = EOC;
    busyNext    = busy;
    overrunNext = overrun;
    if (dOeRise) overrunNext = 1'b0;
    case (state)
      IDLE, READY: begin
        if (convFall) begin
          holdNext  = sampleIn;
          cntNext   = CONV_LOAD;
          busyNext  = 1'b1;
          stateNext = CONVERT;
        end
      end
      CONVERT: begin
        if (convFall) overrunNext = 1'b1;
        if (cnt == '0) begin
          resultNext = hold;
          eocNext    = 1'b0;
          busyNext   = 1'b0;
          cntNext    = EOC_LOAD;
          stateNext  = EOC_PULSE;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      EOC_PULSE: begin
        if (convFall) overrunNext = 1'b1;
        if (cnt == '0) begin
          eocNext   = 1'b1;
          stateNext = READY;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Read path: bus drives the last completed result once the access delay has elapsed.
  always_ff @(posedge Clk or negedge adcRst) begin
    if (!adcRst) begin
      acc <= '0;
      dOe <= 1'b0;
      D   <= '0;
    end else if (rdq) begin
      if (dOe) begin
        D <= result;
      end else if (acc == ACC_LAST) begin
        dOe <= 1'b1;
        D   <= result;
      end else begin
        acc <= acc + ACC_W'(1);
      end
    end else begin
      acc <= '0;
      dOe <= 1'b0;
      D   <= '0;
    end
  end

endmodule

// File: tb/tb_adc_bus_responder.sv
// tb_adc_bus_responder: directed self-checking bench for adc_bus_responder.
// Honours ADC_BUS_RESPONDER_SYNC_EN by shifting strobe-referenced timing by two cycles.
module tb_adc_bus_responder;

  localparam int CONV = 66;
  localparam int EOCW = 10;
  localparam int RDA  = 2;
`ifdef ADC_BUS_RESPONDER_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic       Clk;
  logic       adcRst;
  logic       CONVST;
  logic       CS;
  logic       RD;
  logic [7:0] sampleIn;
  logic [7:0] D;
  logic       dOe;
  logic       EOC;
  logic       busy;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nEdge    = 0;

  adc_bus_responder #(
    .DATA_W(8), .CONV_CYCLES(CONV), .EOC_CYCLES(EOCW), .RD_ACCESS(RDA)
  ) dut (
    .Clk(Clk), .adcRst(adcRst), .CONVST(CONVST), .CS(CS), .RD(RD),
    .sampleIn(sampleIn), .D(D), .dOe(dOe), .EOC(EOC), .busy(busy), .overrun(overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // Drives a CONVST fall and returns just after the edge at which the DUT detects it.
  task automatic startConversion(input logic [7:0] sample);
    sampleIn = sample;
    CONVST   = 1'b0;
    repeat (SYNC + 1) tick();
    CONVST = 1'b1;
    nEdge  = cyc;
  endtask

  task automatic test_reset();
    adcRst = 1'b0; CONVST = 1'b1; CS = 1'b1; RD = 1'b1; sampleIn = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      CONVST = i[0];
      CS     = i[1];
      RD     = i[1];
      tick();
      checks++;
      if ({D, dOe, EOC, busy, overrun} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL reset_hold: got D=%h dOe=%b EOC=%b busy=%b overrun=%b, expected D=00 dOe=0 EOC=1 busy=0 overrun=0",
                 D, dOe, EOC, busy, overrun);
      end
    end
    CONVST = 1'b1; CS = 1'b1; RD = 1'b1;
    adcRst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({dOe, EOC, busy} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL reset_release: got dOe=%b EOC=%b busy=%b, expected 0 1 0", dOe, EOC, busy);
    end
  endtask

  task automatic test_read_idle();
    CS = 1'b0; RD = 1'b0;
    repeat (RDA - 1 + SYNC) tick();
    checks++;
    if (dOe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_read_early: got dOe=%b, expected 0", dOe);
    end
    tick();
    checks++;
    if ({dOe, D} !== {1'b1, 8'h00}) begin
      failures++;
      $display("[TB] FAIL idle_read_data: got dOe=%b D=%h, expected dOe=1 D=00", dOe, D);
    end
    CS = 1'b1; RD = 1'b1;
    repeat (SYNC) tick();
    checks++;
    if (dOe !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_release_early: got dOe=%b, expected 1", dOe);
    end
    tick();
    checks++;
    if ({dOe, D} !== {1'b0, 8'h00}) begin
      failures++;
      $display("[TB] FAIL idle_release: got dOe=%b D=%h, expected dOe=0 D=00", dOe, D);
    end
  endtask

  task automatic test_conversion();
    startConversion(8'hA5);
    sampleIn = 8'h11;
    checks++;
    if ({busy, EOC} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL conv_start: got busy=%b EOC=%b, expected 1 1", busy, EOC);
    end
    for (int k = 1; k < CONV; k++) begin
      tick();
      checks++;
      if ({busy, EOC} !== 2'b11) begin
        failures++;
        $display("[TB] FAIL conv_busy_window: cycle n+%0d got busy=%b EOC=%b, expected 1 1", k, busy, EOC);
      end
    end
    tick();
    checks++;
    if ({busy, EOC} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL conv_eoc_fall: got busy=%b EOC=%b, expected 0 0", busy, EOC);
    end
    for (int k = 1; k < EOCW; k++) begin
      tick();
      checks++;
      if (EOC !== 1'b0) begin
        failures++;
        $display("[TB] FAIL conv_eoc_width: cycle %0d of pulse got EOC=%b, expected 0", k, EOC);
      end
    end
    tick();
    checks++;
    if (EOC !== 1'b1) begin
      failures++;
      $display("[TB] FAIL conv_eoc_rise: got EOC=%b, expected 1", EOC);
    end
    CS = 1'b0; RD = 1'b0;
    repeat (RDA - 1 + SYNC) tick();
    checks++;
    if (dOe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL conv_read_early: got dOe=%b, expected 0", dOe);
    end
    tick();
    checks++;
    if ({dOe, D} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL conv_read_data: got dOe=%b D=%h, expected dOe=1 D=a5", dOe, D);
    end
    CS = 1'b1; RD = 1'b1;
    repeat (SYNC + 1) tick();
    checks++;
    if ({dOe, D} !== {1'b0, 8'h00}) begin
      failures++;
      $display("[TB] FAIL conv_read_release: got dOe=%b D=%h, expected dOe=0 D=00", dOe, D);
    end
  endtask

  task automatic test_overrun();
    startConversion(8'hA5);
    repeat (19) tick();
    sampleIn = 8'h3C;
    CONVST   = 1'b0;
    repeat (SYNC + 1) tick();
    CONVST = 1'b1;
    checks++;
    if ({overrun, busy} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL ovr_set: got overrun=%b busy=%b, expected 1 1", overrun, busy);
    end
    while (cyc < nEdge + CONV - 1) tick();
    checks++;
    if (EOC !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovr_eoc_not_early: got EOC=%b, expected 1", EOC);
    end
    tick();
    checks++;
    if (EOC !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovr_eoc_fall: got EOC=%b, expected 0", EOC);
    end
    while (cyc < nEdge + CONV + EOCW) tick();
    checks++;
    if ({EOC, overrun} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL ovr_eoc_rise: got EOC=%b overrun=%b, expected 1 1", EOC, overrun);
    end
    CS = 1'b0; RD = 1'b0;
    repeat (RDA - 1 + SYNC) tick();
    checks++;
    if ({dOe, overrun} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL ovr_sticky: got dOe=%b overrun=%b, expected 0 1", dOe, overrun);
    end
    tick();
    checks++;
    if ({dOe, D, overrun} !== {1'b1, 8'hA5, 1'b0}) begin
      failures++;
      $display("[TB] FAIL ovr_clear_read: got dOe=%b D=%h overrun=%b, expected 1 a5 0", dOe, D, overrun);
    end
    CS = 1'b1; RD = 1'b1;
    repeat (SYNC + 1) tick();
  endtask

  task automatic test_back_to_back();
    startConversion(8'h3C);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_restart: got busy=%b, expected 1", busy);
    end
    CS = 1'b0; RD = 1'b0;
    repeat (RDA + SYNC) tick();
    checks++;
    if ({dOe, D} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL b2b_read_during_conv: got dOe=%b D=%h, expected 1 a5", dOe, D);
    end
    while (cyc < nEdge + CONV) tick();
    checks++;
    if ({EOC, D} !== {1'b0, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL b2b_update_edge: got EOC=%b D=%h, expected 0 a5", EOC, D);
    end
    tick();
    checks++;
    if (D !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL b2b_track_result: got D=%h, expected 3c", D);
    end
    CS = 1'b1; RD = 1'b1;
    while (cyc < nEdge + CONV + EOCW) tick();
    checks++;
    if ({EOC, dOe, overrun} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL b2b_end: got EOC=%b dOe=%b overrun=%b, expected 1 0 0", EOC, dOe, overrun);
    end
  endtask

  task automatic test_reset_mid_conversion();
    startConversion(8'h77);
    CS = 1'b0; RD = 1'b0;
    repeat (RDA + SYNC) tick();
    checks++;
    if ({dOe, D} !== {1'b1, 8'h3C}) begin
      failures++;
      $display("[TB] FAIL rst_prev_result: got dOe=%b D=%h, expected 1 3c", dOe, D);
    end
    CS = 1'b1; RD = 1'b1;
    while (cyc < nEdge + 30) tick();
    adcRst = 1'b0;
    #1;
    checks++;
    if ({busy, EOC, dOe} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL rst_async_abort: got busy=%b EOC=%b dOe=%b, expected 0 1 0", busy, EOC, dOe);
    end
    repeat (2) tick();
    adcRst = 1'b1;
    for (int k = 0; k < CONV + EOCW; k++) begin
      tick();
      checks++;
      if ({EOC, busy} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL rst_no_eoc: cycle %0d after reset got EOC=%b busy=%b, expected 1 0", k, EOC, busy);
      end
    end
    CS = 1'b0; RD = 1'b0;
    repeat (RDA + SYNC) tick();
    checks++;
    if ({dOe, D, overrun} !== {1'b1, 8'h00, 1'b0}) begin
      failures++;
      $display("[TB] FAIL rst_result_cleared: got dOe=%b D=%h overrun=%b, expected 1 00 0", dOe, D, overrun);
    end
    CS = 1'b1; RD = 1'b1;
    repeat (SYNC + 1) tick();
  endtask

  initial begin
    $display("[TB] adc_bus_responder bench, strobe sync latency %0d", SYNC);
    test_reset();
    test_read_idle();
    test_conversion();
    test_overrun();
    test_back_to_back();
    test_reset_mid_conversion();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
